display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter_if.sv | 21 ++
 rtl/display_arbiter.sv | 137 +++++++++++++
 tb/tb_display_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// Request/display bundle between up to four display clients and the arbiter.
// master = requester side, slave = arbiter side.
interface display_arbiter_if;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [3:0]   hex_in;
  logic [3:0]   gnt;
  logic [31:0]  disp_data;
  logic         disp_isHex;
  logic         owner_valid;

  modport master (
    output req, data_in, hex_in,
    input  gnt, disp_data, disp_isHex, owner_valid
  );

  modport slave (
    input  req, data_in, hex_in,
    output gnt, disp_data, disp_isHex, owner_valid
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one dynamic display among four requesters with a minimum hold time.
// Registered outputs, one cycle req-to-gnt; owner keeps the display for HOLD cycles unless it releases early.
module display_arbiter #(
  parameter int unsigned HOLD       = 16,
  parameter logic [31:0] BLANK_DATA = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  display_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SHARE
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_is_hex_q, disp_is_hex_d;
  logic        owner_valid_q, owner_valid_d;

  logic        owner_req;
  logic [3:0]  others;
  logic [2:0]  any_pick;
  logic [2:0]  other_pick;
  logic        do_grant;
  logic        do_release;
  logic [1:0]  grant_idx;

  // Returns {found, index}; searches last+1, last+2, last+3, last+0.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
    logic [1:0] c;
    logic [2:0] res;
    res = {1'b0, last};
    for (int k = 1; k <= 4; k++) begin
      c = last + 2'(k);
      if (!res[2] && mask[c]) begin
        res = {1'b1, c};
      end
    end
    return res;
  endfunction

  // While owned, last_owner always names the current owner.
  assign owner_req  = bus.req[last_owner_q];
  assign others     = bus.req & ~gnt_q;
  assign any_pick   = rr_pick(bus.req, last_owner_q);
  assign other_pick = rr_pick(others, last_owner_q);

  always_comb begin
    do_grant   = 1'b0;
    do_release = 1'b0;
    grant_idx  = other_pick[1:0];
    cnt_d      = cnt_q;
    state_d    = state_q;

    case (state_q)
      S_IDLE: begin
        if (any_pick[2]) begin
          do_grant  = 1'b1;
          grant_idx = any_pick[1:0];
        end
      end
      default: begin
        if (!owner_req) begin
          if (other_pick[2]) begin
            do_grant = 1'b1;
          end else begin
            do_release = 1'b1;
          end
        end else if (state_q == S_HOLD && cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (other_pick[2]) begin
          do_grant = 1'b1;
        end else begin
          state_d = S_SHARE;
        end
      end
    endcase

    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    if (do_grant) begin
      state_d      = S_HOLD;
      gnt_d        = 4'b0001 << grant_idx;
      cnt_d        = CNT_RELOAD;
      last_owner_d = grant_idx;
    end else if (do_release) begin
      state_d = S_IDLE;
      gnt_d   = 4'b0000;
      cnt_d   = 8'd0;
    end

    // Display follows the next-cycle owner so gnt and data move together.
    if (state_d != S_IDLE) begin
      disp_data_d   = bus.data_in[{last_owner_d, 5'b00000} +: 32];
      disp_is_hex_d = bus.hex_in[last_owner_d];
      owner_valid_d = 1'b1;
    end else begin
      disp_data_d   = BLANK_DATA;
      disp_is_hex_d = 1'b1;
      owner_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gnt_q         <= 4'b0000;
      cnt_q         <= 8'd0;
      last_owner_q  <= 2'd3;
      disp_data_q   <= BLANK_DATA;
      disp_is_hex_q <= 1'b1;
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      last_owner_q  <= last_owner_d;
      disp_data_q   <= disp_data_d;
      disp_is_hex_q <= disp_is_hex_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.disp_data   = disp_data_q;
  assign bus.disp_isHex  = disp_is_hex_q;
  assign bus.owner_valid = owner_valid_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: an ownership/age model checked every cycle plus literal spot checks.
module tb_display_arbiter;

  localparam int          HOLD_C  = 16;
  localparam logic [31:0] BLANK_C = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  display_arbiter_if bus ();

  display_arbiter #(.HOLD(HOLD_C), .BLANK_DATA(BLANK_C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: current owner (-1 = none), edges owned since grant, round-robin pointer.
  int          m_owner;
  int          m_age;
  int          m_last;
  logic [31:0] m_data;
  logic        m_hex;

  function automatic int pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_age   = 0;
      m_last  = 3;
    end else begin
      int w;
      logic [3:0] oth;
      if (m_owner < 0) begin
        w = pick(bus.req, m_last);
      end else begin
        oth = bus.req;
        oth[m_owner] = 1'b0;
        if (!bus.req[m_owner]) w = pick(oth, m_last);
        else if (m_age < HOLD_C) begin
          m_age = m_age + 1;
          w = -2;
        end else begin
          w = pick(oth, m_last);
          if (w < 0) w = -2;
        end
      end
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_age   = 1;
      end else if (w == -1) begin
        m_owner = -1;
      end
    end
    if (m_owner >= 0) begin
      m_data = bus.data_in[32*m_owner +: 32];
      m_hex  = bus.hex_in[m_owner];
    end else begin
      m_data = BLANK_C;
      m_hex  = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("model_gnt", 32'(bus.gnt), 32'(eg));
    chk("model_data", bus.disp_data, m_data);
    chk("model_hex", 32'(bus.disp_isHex), 32'(m_hex));
    chk("model_valid", 32'(bus.owner_valid), 32'(m_owner >= 0));
  end

  task automatic jitter();
    bus.data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.hex_in  = 4'($urandom());
  endtask

  initial begin
    bus.req     = 4'b1111;
    bus.data_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_F00D};
    bus.hex_in  = 4'b0000;

    // Reset holds outputs quiet despite requests.
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_data", bus.disp_data, 32'h0);
    chk("rst_hex", 32'(bus.disp_isHex), 32'h1);
    chk("rst_valid", 32'(bus.owner_valid), 32'h0);
    rst = 1'b0;
    bus.req = 4'b0000;
    @(negedge clk);

    // Single requester with live data tracking.
    bus.req = 4'b0100;
    bus.data_in[95:64] = 32'h00ff_00ff;
    bus.hex_in = 4'b0100;
    @(negedge clk);
    chk("single_gnt", 32'(bus.gnt), 32'h4);
    chk("single_data", bus.disp_data, 32'h00ff_00ff);
    chk("single_hex", 32'(bus.disp_isHex), 32'h1);
    bus.data_in[95:64] = 32'd1234;
    bus.hex_in = 4'b0000;
    @(negedge clk);
    chk("track_data", bus.disp_data, 32'd1234);
    chk("track_hex", 32'(bus.disp_isHex), 32'h0);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("idle_gnt", 32'(bus.gnt), 32'h0);
    chk("idle_data", bus.disp_data, BLANK_C);

    // Contention: each owner keeps the display for exactly HOLD cycles.
    bus.req = 4'b0011;
    @(negedge clk);
    chk("cont_e1", 32'(bus.gnt), 32'h1);
    repeat (15) begin @(negedge clk); jitter(); end
    chk("cont_e16", 32'(bus.gnt), 32'h1);
    @(negedge clk);
    chk("cont_e17", 32'(bus.gnt), 32'h2);
    repeat (15) begin @(negedge clk); jitter(); end
    chk("cont_e32", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    chk("cont_e33", 32'(bus.gnt), 32'h1);

    // Early release inside the hold window.
    repeat (3) @(negedge clk);
    bus.req = 4'b0010;
    @(negedge clk);
    chk("early_hand", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("early_none_gnt", 32'(bus.gnt), 32'h0);
    chk("early_none_data", bus.disp_data, BLANK_C);
    chk("early_none_valid", 32'(bus.owner_valid), 32'h0);

    // Wrap-around of the round-robin search.
    bus.req = 4'b1000;
    @(negedge clk);
    chk("wrap_own3", 32'(bus.gnt), 32'h8);
    repeat (17) begin @(negedge clk); jitter(); end
    bus.req = 4'b1001;
    @(negedge clk);
    chk("wrap_3to0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0010;
    @(negedge clk);
    chk("wrap_own1", 32'(bus.gnt), 32'h2);
    repeat (17) begin @(negedge clk); jitter(); end
    bus.req = 4'b1011;
    @(negedge clk);
    chk("wrap_1to3", 32'(bus.gnt), 32'h8);

    // Asynchronous reset pulse mid-hold, between edges.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'h0);
    chk("arst_valid", 32'(bus.owner_valid), 32'h0);
    chk("arst_data", bus.disp_data, BLANK_C);
    chk("arst_hex", 32'(bus.disp_isHex), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b0110;
    @(negedge clk);
    chk("post_rst", 32'(bus.gnt), 32'h2);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
